// File: rtl/seg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : seg_pkg                                                   |
// | Purpose  : Seven-segment constants, controller state type and the    |
// |            nibble-to-segment lookup shared by the scan controller.   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package seg_pkg;

  // Active-low segment codes: bit7 = dp, bits6..0 = g..a. dp is off in all.
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_B     = 8'h83;
  localparam logic [7:0] SEG_C     = 8'hC6;
  localparam logic [7:0] SEG_D     = 8'hA1;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_F     = 8'h8E;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  // Load/convert/commit controller states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } scan_state_e;

  // Map a 4-bit digit value onto its segment pattern (dp off).
  function automatic logic [7:0] nib2seg(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_bin2bcd.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : seg_bin2bcd                                               |
// | Purpose  : Iterative double-dabble binary-to-BCD converter, one      |
// |            shift-add-3 step per clock, with overflow detection.      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module seg_bin2bcd #(
  parameter int DATA_W = 27,
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [DATA_W-1:0]     data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  ovf_o
);

  localparam int               BCD_W   = 4 * DIGITS;
  localparam int               CNT_W   = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(DATA_W - 1);
  localparam logic             SINGLE  = (DATA_W == 1);

  logic [DATA_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [BCD_W-1:0]  w_adj;
  logic [BCD_W-1:0]  w_shifted;
  logic              w_shout;

  // One double-dabble step per cycle; the start cycle already performs the
  // first step (add-3 on an all-zero BCD register is a no-op), so the final
  // result is ready DATA_W-1 cycles after start.
  always_comb begin
    w_adj = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        w_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
    {w_shout, w_shifted} = {w_adj, bin_q[DATA_W-1]};

    bin_d  = bin_q;
    bcd_d  = bcd_q;
    ovf_d  = ovf_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start_i) begin
      bin_d  = data_i << 1;
      bcd_d  = BCD_W'(data_i[DATA_W-1]);
      ovf_d  = 1'b0;
      cnt_d  = CNT_W'(1);
      busy_d = !SINGLE;
      done_d = SINGLE;
    end else if (busy_q) begin
      bin_d  = bin_q << 1;
      bcd_d  = w_shifted;
      // Any bit pushed out of the top digit means the value needs more digits.
      ovf_d  = ovf_q | w_shout;
      cnt_d  = cnt_q + 1'b1;
      if (cnt_q == LAST_IT) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // Converter state register; reset abandons any conversion in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      ovf_q  <= ovf_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign bcd_o  = bcd_q;
  assign ovf_o  = ovf_q;

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : seg_scan_ctrl                                             |
// | Purpose  : Multiplexed seven-segment display controller: captures a  |
// |            binary value, converts it to hex or decimal digits and    |
// |            scans them out with dead time, blanking and dp control.   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS   = 8,
  parameter int DATA_W   = 27,
  parameter int SCAN_CYC = 50_000,
  parameter int DEAD_CYC = 500
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load,
  output logic              ready,
  input  logic              hex_mode,
  input  logic              blank_lz,
  input  logic [DIGITS-1:0] dp_mask,
  output logic [DIGITS-1:0] cs,
  output logic [7:0]        dx
);

  localparam int               BCD_W    = 4 * DIGITS;
  localparam int               CNT_W    = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;
  localparam int               IDX_W    = $clog2(DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_CYC - 1);
  localparam logic [CNT_W-1:0] DEAD_END = CNT_W'(DEAD_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  // Load / conversion control
  scan_state_e       state_q, state_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] data_q;
  logic              hex_q;
  logic              blz_cap_q;
  logic              w_accept;
  logic              w_commit;

  // Displayed digit buffer
  logic [BCD_W-1:0]  buf_q;
  logic              dash_q;
  logic              blz_q;

  // Converter handshake
  logic              w_cvt_start;
  logic              w_cvt_busy;
  logic              w_cvt_done;
  logic [BCD_W-1:0]  w_cvt_bcd;
  logic              w_cvt_ovf;

  // Scanner
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DIGITS-1:0] cs_q, cs_d;
  logic [7:0]        dx_q, dx_d;
  logic [DIGITS-1:0] w_lz;
  logic              w_upper_zero;
  logic [3:0]        w_nib;
  logic              w_blank;
  logic              w_dp;
  logic [7:0]        w_seg;
  logic [DIGITS-1:0] w_onehot;

  assign w_accept    = load & ready_q;
  assign w_cvt_start = w_accept & ~hex_mode;

  seg_bin2bcd #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .start_i (w_cvt_start),
    .data_i  (data_in),
    .busy_o  (w_cvt_busy),
    .done_o  (w_cvt_done),
    .bcd_o   (w_cvt_bcd),
    .ovf_o   (w_cvt_ovf)
  );

  // Controller next state; ready is registered so it returns one cycle after COMMIT.
  always_comb begin
    state_d  = state_q;
    ready_d  = ready_q;
    w_commit = 1'b0;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (w_accept) begin
          ready_d = 1'b0;
          state_d = hex_mode ? COMMIT : CONV;
        end
      end
      CONV: begin
        ready_d = 1'b0;
        if (w_cvt_done) begin
          state_d = COMMIT;
        end else if (!w_cvt_busy) begin
          // Converter lost its job (cannot occur in normal operation): recover.
          state_d = IDLE;
        end
      end
      COMMIT: begin
        ready_d  = 1'b0;
        w_commit = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        ready_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Controller registers, load capture and atomic digit-buffer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ready_q   <= 1'b1;
      data_q    <= '0;
      hex_q     <= 1'b0;
      blz_cap_q <= 1'b0;
      buf_q     <= '0;
      dash_q    <= 1'b0;
      blz_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      if (w_accept) begin
        data_q    <= data_in;
        hex_q     <= hex_mode;
        blz_cap_q <= blank_lz;
      end
      if (w_commit) begin
        buf_q  <= hex_q ? BCD_W'(data_q) : w_cvt_bcd;
        dash_q <= ~hex_q & w_cvt_ovf;
        blz_q  <= blz_cap_q;
      end
    end
  end

  // Leading-zero map: digit k is blanked when it and every digit above it are zero.
  always_comb begin
    w_lz         = '0;
    w_upper_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      w_upper_zero = w_upper_zero & (buf_q[4*k +: 4] == 4'd0);
      w_lz[k]      = blz_q & w_upper_zero;
    end
  end

  // Slot timing and the registered cs/dx for the digit selected next cycle.
  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    w_nib   = '0;
    w_blank = 1'b0;
    w_dp    = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_d == IDX_W'(k)) begin
        w_nib   = buf_q[4*k +: 4];
        w_blank = w_lz[k];
        w_dp    = dp_mask[k];
      end
    end

    w_seg = nib2seg(w_nib);
    if (dash_q) begin
      w_seg = SEG_DASH;
    end else if (w_blank) begin
      w_seg = SEG_BLANK;
    end
    // dp follows the live mask, even on blanked or dashed digits.
    dx_d = {w_seg[7] & ~w_dp, w_seg[6:0]};

    w_onehot = {{(DIGITS-1){1'b0}}, 1'b1} << idx_d;
    cs_d     = (cnt_d >= DEAD_END) ? ~w_onehot : '1;
  end

  // Scanner registers; runs continuously regardless of load activity.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      cs_q  <= '1;
      dx_q  <= SEG_BLANK;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      cs_q  <= cs_d;
      dx_q  <= dx_d;
    end
  end

  assign ready = ready_q;
  assign cs    = cs_q;
  assign dx    = dx_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_seg_scan_ctrl                                          |
// | Purpose  : Self-checking bench for seg_scan_ctrl with a value-level  |
// |            display model and hand-computed digit expectations.       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_seg_scan_ctrl;

  localparam int DIGITS   = 8;
  localparam int DATA_W   = 27;
  localparam int SCAN_CYC = 10;
  localparam int DEAD_CYC = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] data_in;
  logic              load;
  logic              ready;
  logic              hex_mode;
  logic              blank_lz;
  logic [DIGITS-1:0] dp_mask;
  logic [DIGITS-1:0] cs;
  logic [7:0]        dx;

  int total = 0;
  int bad   = 0;

  seg_scan_ctrl #(
    .DIGITS   (DIGITS),
    .DATA_W   (DATA_W),
    .SCAN_CYC (SCAN_CYC),
    .DEAD_CYC (DEAD_CYC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .load     (load),
    .ready    (ready),
    .hex_mode (hex_mode),
    .blank_lz (blank_lz),
    .dp_mask  (dp_mask),
    .cs       (cs),
    .dx       (dx)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model (value level) ----------------
  logic              m_valid = 1'b0;
  logic              m_inrst = 1'b0;
  int                m_t     = 0;      // cycles since reset release
  logic              m_rdy   = 1'b1;
  int                m_left  = 0;      // cycles until ready returns
  longint            m_val   = 0;      // value shown on the display
  logic              m_hex   = 1'b0;
  logic              m_blz   = 1'b0;
  longint            p_val   = 0;      // value waiting to be shown
  logic              p_hex   = 1'b0;
  logic              p_blz   = 1'b0;
  logic [DIGITS-1:0] m_dp    = '0;

  always @(posedge clk) begin
    m_dp <= dp_mask;
    if (rst) begin
      m_valid <= 1'b1;
      m_inrst <= 1'b1;
      m_t     <= 0;
      m_rdy   <= 1'b1;
      m_left  <= 0;
      m_val   <= 0;
      m_hex   <= 1'b0;
      m_blz   <= 1'b0;
    end else begin
      m_inrst <= 1'b0;
      m_t     <= m_t + 1;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_val <= p_val;
          m_hex <= p_hex;
          m_blz <= p_blz;
          m_rdy <= 1'b1;
        end
      end else if (load && m_rdy) begin
        p_val  <= longint'(data_in);
        p_hex  <= hex_mode;
        p_blz  <= blank_lz;
        m_rdy  <= 1'b0;
        m_left <= hex_mode ? 2 : DATA_W + 2;
      end
    end
  end

  function automatic logic [7:0] seg_tab(input int n);
    case (n)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90; 10: return 8'h88; 11: return 8'h83;
      12: return 8'hC6; 13: return 8'hA1; 14: return 8'h86; default: return 8'h8E;
    endcase
  endfunction

  function automatic logic [7:0] exp_dx(input int idx);
    longint     p10  = 1;
    longint     full = 1;
    int         nib;
    logic       blank;
    logic [7:0] s;
    for (int k = 0; k < idx; k++) p10 = p10 * 10;
    for (int k = 0; k < DIGITS; k++) full = full * 10;
    if (!m_hex && m_val >= full) begin
      s = 8'hBF;
    end else begin
      nib   = m_hex ? int'((m_val >> (4 * idx)) & 15) : int'((m_val / p10) % 10);
      blank = m_blz && idx > 0 && (m_hex ? ((m_val >> (4 * idx)) == 0) : (m_val < p10));
      s     = blank ? 8'hFF : seg_tab(nib);
    end
    s[7] = ~m_dp[idx];
    return s;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic wait_sel(input int i);
    logic found;
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      if (cs == ~(DIGITS'(1) << i)) found = 1'b1;
    end
    chk("digit_select_seen", {31'd0, found}, 32'd1);
  endtask

  // Load one value; optionally fire a second load while busy. Returns ready-low cycles.
  task automatic do_load(input logic [DATA_W-1:0] v, input logic hx, input logic bz,
                         input logic inject, output int low);
    logic back;
    low  = 0;
    back = 1'b0;
    @(posedge clk); #2;
    data_in = v; hex_mode = hx; blank_lz = bz; load = 1'b1;
    @(posedge clk); #2;
    load = 1'b0;
    for (int n = 0; n < 100 && !back; n++) begin
      @(negedge clk);
      if (load) load = 1'b0;
      if (ready) begin
        back = 1'b1;
      end else begin
        low++;
        if (inject && low == 5) begin
          data_in = 27'd87654321; hex_mode = 1'b0; load = 1'b1;
        end
      end
    end
    chk("ready_returned", {31'd0, back}, 32'd1);
  endtask

  // ---------------- stimulus and comparisons ----------------
  initial begin
    int lowc;
    rst = 1'b1; load = 1'b0; data_in = '0; hex_mode = 1'b0; blank_lz = 1'b0; dp_mask = '0;

    // Per-cycle compare of every output against the model.
    fork
      begin
        forever begin
          logic [DIGITS-1:0] e_cs;
          logic [7:0]        e_dx;
          logic              e_rdy;
          int                c, ix;
          @(negedge clk);
          if (m_valid) begin
            if (m_inrst) begin
              e_cs = '1; e_dx = 8'hFF; e_rdy = 1'b1;
            end else begin
              c     = m_t % SCAN_CYC;
              ix    = (m_t / SCAN_CYC) % DIGITS;
              e_cs  = (c < DEAD_CYC) ? '1 : ~(DIGITS'(1) << ix);
              e_dx  = exp_dx(ix);
              e_rdy = m_rdy;
            end
            chk("cyc_cs", 32'(cs), 32'(e_cs));
            chk("cyc_dx", 32'(dx), 32'(e_dx));
            chk("cyc_ready", 32'(ready), 32'(e_rdy));
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Scan timing after release: 2 dead cycles, 8 selected, then slot 1.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      chk("scan_cs", 32'(cs), (i % 10 < 2) ? 32'hFF : (i < 10 ? 32'hFE : 32'hFD));
      if (i == 2) chk("reset_digit0", 32'(dx), 32'hC0);
      if (i == 0) chk("reset_ready", 32'(ready), 32'd1);
    end

    // Live decimal point on digit 2 only.
    dp_mask = 8'h04;
    wait_sel(2); chk("dp_slot2", 32'(dx[7]), 32'd0);
    wait_sel(3); chk("dp_slot3", 32'(dx[7]), 32'd1);
    dp_mask = 8'h00;

    // Decimal 25_123_456.
    do_load(27'd25123456, 1'b0, 1'b0, 1'b0, lowc);
    chk("dec_ready_low", 32'(lowc), 32'd29);
    wait_sel(0); chk("dec_digit0", 32'(dx), 32'h82);
    wait_sel(1); chk("dec_digit1", 32'(dx), 32'h92);
    wait_sel(7); chk("dec_digit7", 32'(dx), 32'hA4);

    // Hex 0x0ABCDEF with leading-zero blanking.
    do_load(27'h0ABCDEF, 1'b1, 1'b1, 1'b0, lowc);
    chk("hex_ready_low", 32'(lowc), 32'd2);
    wait_sel(7); chk("hex_digit7", 32'(dx), 32'hFF);
    wait_sel(6); chk("hex_digit6", 32'(dx), 32'hFF);
    wait_sel(5); chk("hex_digit5", 32'(dx), 32'h88);
    wait_sel(0); chk("hex_digit0", 32'(dx), 32'h8E);

    // Decimal overflow: 10^8 shows dashes everywhere.
    do_load(27'd100000000, 1'b0, 1'b0, 1'b0, lowc);
    wait_sel(3); chk("ovf_digit3", 32'(dx), 32'hBF);
    wait_sel(0); chk("ovf_digit0", 32'(dx), 32'hBF);

    // Decimal zero with blanking.
    do_load(27'd0, 1'b0, 1'b1, 1'b0, lowc);
    wait_sel(0); chk("zero_digit0", 32'(dx), 32'hC0);
    wait_sel(4); chk("zero_digit4", 32'(dx), 32'hFF);

    // Second load during conversion is dropped.
    do_load(27'd12345678, 1'b0, 1'b0, 1'b1, lowc);
    chk("inject_ready_low", 32'(lowc), 32'd29);
    wait_sel(7); chk("inject_digit7", 32'(dx), 32'hF9);
    wait_sel(0); chk("inject_digit0", 32'(dx), 32'h80);

    // Reset in the middle of a conversion.
    @(posedge clk); #2;
    data_in = 27'd55555555; hex_mode = 1'b0; blank_lz = 1'b0; load = 1'b1;
    @(posedge clk); #2;
    load = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_dx", 32'(dx), 32'hFF);
    chk("rst_cs", 32'(cs), 32'hFF);
    chk("rst_ready", 32'(ready), 32'd1);
    @(posedge clk); #2 rst = 1'b0;
    wait_sel(7); chk("rst_buf_digit7", 32'(dx), 32'hC0);
    wait_sel(0); chk("rst_buf_digit0", 32'(dx), 32'hC0);

    repeat (90) @(posedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
